// File: rtl/orbit_engine_if.sv
// orbit_engine_if: configuration write port and result stream of orbit_engine.
// master = host side (writes config, consumes results), slave = engine side.
interface orbit_engine_if #(
   parameter int N_CH    = 4,
   parameter int ANGLE_W = 9,
   parameter int COORD_W = 10
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic                      cfg_we;
   logic [CH_W-1:0]           cfg_ch;
   logic [COORD_W-1:0]        cfg_cx;
   logic [COORD_W-1:0]        cfg_cy;
   logic [COORD_W-1:0]        cfg_r;
   logic signed [ANGLE_W-1:0] cfg_step;
   logic [ANGLE_W-1:0]        cfg_phase;
   logic                      cfg_phase_we;

   logic                      out_valid;
   logic                      out_ready;
   logic [CH_W-1:0]           out_ch;
   logic [COORD_W-1:0]        out_x;
   logic [COORD_W-1:0]        out_y;

   modport master (
      output cfg_we, cfg_ch, cfg_cx, cfg_cy, cfg_r, cfg_step, cfg_phase, cfg_phase_we,
      output out_ready,
      input  out_valid, out_ch, out_x, out_y
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_cx, cfg_cy, cfg_r, cfg_step, cfg_phase, cfg_phase_we,
      input  out_ready,
      output out_valid, out_ch, out_x, out_y
   );
endinterface

// File: rtl/orbit_engine.sv
// orbit_engine: per-channel circular orbit generator. Each frame_tick sweeps all
// channels, emitting X = cx + r*cos(a), Y = cy + r*sin(a) (screen Y grows downward),
// then advancing each channel's angle by its signed step.
// Optional feature: define ORBIT_CLAMP_EN to saturate X/Y to the coordinate range
// instead of wrapping modulo 2^COORD_W.
//
// state  | meaning
// IDLE   | waiting for frame_tick or a pending request
// LOAD   | snapshot channel ch, write back advanced angle
// SIN    | quarter-wave lookup of sin(a)
// COS    | quarter-wave lookup of cos(a) = sin(a + Q)
// MUL    | scale by radius, round, add to centre, register result
// EMIT   | hold result until out_ready
// DONE   | one-cycle sweep_done pulse
module orbit_engine #(
   parameter int N_CH    = 4,
   parameter int ANGLE_W = 9,
   parameter int COORD_W = 10
) (
   input  logic          CLK,
   input  logic          Reset_n,
   input  logic          frame_tick,
   orbit_engine_if.slave bus,
   output logic          busy,
   output logic          sweep_done,
   output logic          overrun
);
   localparam int  CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int  FRAC_W = 10;
   localparam int  Q      = 1 << (ANGLE_W - 2);
   localparam int  IDX_W  = ANGLE_W - 1;
   localparam int  P_W    = COORD_W + FRAC_W + 2;
   localparam int  S_W    = COORD_W + 2;
   localparam real PI     = 3.14159265358979323846;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SIN, S_COS, S_MUL, S_EMIT, S_DONE} state_t;

   function automatic int quarter_sine(input int k);
      return $rtoi(real'(1 << FRAC_W) * $sin(PI / 2.0 * real'(k) / real'(Q)) + 0.5);
   endfunction

   // Quarter-wave table, entries 0..Q inclusive so that sin(90 deg) is exactly 1.0.
   logic [FRAC_W:0] rom [Q+1];
   for (genvar g = 0; g <= Q; g++) begin : g_rom
      localparam int TV = quarter_sine(g);
      assign rom[g] = TV[FRAC_W:0];
   end

   // channel register file
   logic [COORD_W-1:0] cx_q    [N_CH], cx_d    [N_CH];
   logic [COORD_W-1:0] cy_q    [N_CH], cy_d    [N_CH];
   logic [COORD_W-1:0] r_q     [N_CH], r_d     [N_CH];
   logic [ANGLE_W-1:0] step_q  [N_CH], step_d  [N_CH];
   logic [ANGLE_W-1:0] angle_q [N_CH], angle_d [N_CH];

   // sweep state and registered outputs
   state_t             state_q, state_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic               pending_q, pending_d;
   logic               overrun_q, overrun_d;
   logic               busy_q, busy_d;
   logic               sweep_done_q, sweep_done_d;
   logic               out_valid_q, out_valid_d;
   logic [CH_W-1:0]    out_ch_q, out_ch_d;
   logic [COORD_W-1:0] out_x_q, out_x_d;
   logic [COORD_W-1:0] out_y_q, out_y_d;
   logic [COORD_W-1:0] cx_s_q, cx_s_d;
   logic [COORD_W-1:0] cy_s_q, cy_s_d;
   logic [COORD_W-1:0] r_s_q, r_s_d;
   logic [ANGLE_W-1:0] ang_s_q, ang_s_d;
   logic [FRAC_W:0]    sin_mag_q, sin_mag_d;
   logic [FRAC_W:0]    cos_mag_q, cos_mag_d;
   logic               sin_neg_q, sin_neg_d;
   logic               cos_neg_q, cos_neg_d;

   logic               cfg_ok;
   logic [ANGLE_W-1:0] ang_c;
   logic [IDX_W-1:0]   sin_idx, cos_idx;
   logic [P_W-1:0]     prod_x, prod_y;
   logic [S_W-1:0]     dx, dy, sum_x, sum_y;
   logic [COORD_W-1:0] x_res, y_res;
   logic               unused_bits;

   assign cfg_ok = int'(bus.cfg_ch) < N_CH;

   // Host writes land in any state; a phase write beats the LOAD angle advance.
   always_comb begin
      cx_d    = cx_q;
      cy_d    = cy_q;
      r_d     = r_q;
      step_d  = step_q;
      angle_d = angle_q;
      if (state_q == S_LOAD)
         angle_d[ch_q] = angle_q[ch_q] + step_q[ch_q];
      if (cfg_ok && bus.cfg_we) begin
         cx_d[bus.cfg_ch]   = bus.cfg_cx;
         cy_d[bus.cfg_ch]   = bus.cfg_cy;
         r_d[bus.cfg_ch]    = bus.cfg_r;
         step_d[bus.cfg_ch] = bus.cfg_step;
      end
      if (cfg_ok && bus.cfg_phase_we)
         angle_d[bus.cfg_ch] = bus.cfg_phase;
   end

   // Channel register file storage.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < N_CH; i++) begin
            cx_q[i]    <= '0;
            cy_q[i]    <= '0;
            r_q[i]     <= '0;
            step_q[i]  <= '0;
            angle_q[i] <= '0;
         end
      end else begin
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         r_q     <= r_d;
         step_q  <= step_d;
         angle_q <= angle_d;
      end
   end

   // Fold the snapshot angle into a quarter-wave index and a sign, for sin and cos.
   always_comb begin
      ang_c   = ang_s_q + ANGLE_W'(Q);
      sin_idx = ang_s_q[ANGLE_W-2] ? IDX_W'(Q) - IDX_W'(ang_s_q[ANGLE_W-3:0])
                                   : IDX_W'(ang_s_q[ANGLE_W-3:0]);
      cos_idx = ang_c[ANGLE_W-2]   ? IDX_W'(Q) - IDX_W'(ang_c[ANGLE_W-3:0])
                                   : IDX_W'(ang_c[ANGLE_W-3:0]);
   end

   // Radius scaling with round-half-up on the magnitude, sign applied afterwards.
   always_comb begin
      prod_x = P_W'(r_s_q) * P_W'(cos_mag_q) + P_W'(1 << (FRAC_W - 1));
      prod_y = P_W'(r_s_q) * P_W'(sin_mag_q) + P_W'(1 << (FRAC_W - 1));
      dx     = prod_x[P_W-1:FRAC_W];
      dy     = prod_y[P_W-1:FRAC_W];
      sum_x  = S_W'(cx_s_q) + (cos_neg_q ? -dx : dx);
      sum_y  = S_W'(cy_s_q) + (sin_neg_q ? -dy : dy);
`ifdef ORBIT_CLAMP_EN
      if (sum_x[S_W-1])      x_res = '0;
      else if (sum_x[S_W-2]) x_res = '1;
      else                   x_res = sum_x[COORD_W-1:0];
      if (sum_y[S_W-1])      y_res = '0;
      else if (sum_y[S_W-2]) y_res = '1;
      else                   y_res = sum_y[COORD_W-1:0];
`else
      x_res = sum_x[COORD_W-1:0];
      y_res = sum_y[COORD_W-1:0];
`endif
   end

   assign unused_bits = ^{prod_x[FRAC_W-1:0], prod_y[FRAC_W-1:0], sum_x, sum_y};

   // Sweep sequencing, request bookkeeping and datapath staging.
   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      pending_d    = pending_q;
      overrun_d    = overrun_q;
      sweep_done_d = 1'b0;
      out_valid_d  = out_valid_q;
      out_ch_d     = out_ch_q;
      out_x_d      = out_x_q;
      out_y_d      = out_y_q;
      cx_s_d       = cx_s_q;
      cy_s_d       = cy_s_q;
      r_s_d        = r_s_q;
      ang_s_d      = ang_s_q;
      sin_mag_d    = sin_mag_q;
      sin_neg_d    = sin_neg_q;
      cos_mag_d    = cos_mag_q;
      cos_neg_d    = cos_neg_q;

      if (frame_tick && state_q != S_IDLE) begin
         if (pending_q) overrun_d = 1'b1;
         else           pending_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (frame_tick || pending_q) begin
               state_d   = S_LOAD;
               ch_d      = '0;
               pending_d = 1'b0;
            end
         end
         S_LOAD: begin
            cx_s_d  = cx_q[ch_q];
            cy_s_d  = cy_q[ch_q];
            r_s_d   = r_q[ch_q];
            ang_s_d = angle_q[ch_q];
            state_d = S_SIN;
         end
         S_SIN: begin
            sin_mag_d = rom[sin_idx];
            sin_neg_d = ang_s_q[ANGLE_W-1];
            state_d   = S_COS;
         end
         S_COS: begin
            cos_mag_d = rom[cos_idx];
            cos_neg_d = ang_c[ANGLE_W-1];
            state_d   = S_MUL;
         end
         S_MUL: begin
            out_x_d     = x_res;
            out_y_d     = y_res;
            out_ch_d    = ch_q;
            out_valid_d = 1'b1;
            state_d     = S_EMIT;
         end
         S_EMIT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (ch_q == CH_W'(N_CH - 1)) begin
                  state_d      = S_DONE;
                  sweep_done_d = 1'b1;
               end else begin
                  ch_d    = ch_q + 1'b1;
                  state_d = S_LOAD;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // FSM state and registered outputs.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= S_IDLE;
         ch_q         <= '0;
         pending_q    <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
         sweep_done_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_ch_q     <= '0;
         out_x_q      <= '0;
         out_y_q      <= '0;
         cx_s_q       <= '0;
         cy_s_q       <= '0;
         r_s_q        <= '0;
         ang_s_q      <= '0;
         sin_mag_q    <= '0;
         sin_neg_q    <= 1'b0;
         cos_mag_q    <= '0;
         cos_neg_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         busy_q       <= busy_d;
         sweep_done_q <= sweep_done_d;
         out_valid_q  <= out_valid_d;
         out_ch_q     <= out_ch_d;
         out_x_q      <= out_x_d;
         out_y_q      <= out_y_d;
         cx_s_q       <= cx_s_d;
         cy_s_q       <= cy_s_d;
         r_s_q        <= r_s_d;
         ang_s_q      <= ang_s_d;
         sin_mag_q    <= sin_mag_d;
         sin_neg_q    <= sin_neg_d;
         cos_mag_q    <= cos_mag_d;
         cos_neg_q    <= cos_neg_d;
      end
   end

   assign busy          = busy_q;
   assign sweep_done    = sweep_done_q;
   assign overrun       = overrun_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_x     = out_x_q;
   assign bus.out_y     = out_y_q;
endmodule

// File: tb/tb_orbit_engine.sv
// tb_orbit_engine: directed and randomized sweeps of orbit_engine, checked by a
// scoreboard fed from a trigonometric reference model.
module tb_orbit_engine;
   localparam int  N_CH    = 4;
   localparam int  ANGLE_W = 9;
   localparam int  COORD_W = 10;
   localparam int  CH_W    = 2;
   localparam int  FULL    = 1 << ANGLE_W;
   localparam int  CMOD    = 1 << COORD_W;
   localparam real PI      = 3.14159265358979323846;

   typedef struct {int ch; int x; int y;} exp_t;

   logic CLK;
   logic Reset_n;
   logic frame_tick;
   logic busy, sweep_done, overrun;

   orbit_engine_if #(.N_CH(N_CH), .ANGLE_W(ANGLE_W), .COORD_W(COORD_W)) bus ();

   orbit_engine #(.N_CH(N_CH), .ANGLE_W(ANGLE_W), .COORD_W(COORD_W)) dut (
      .CLK        (CLK),
      .Reset_n    (Reset_n),
      .frame_tick (frame_tick),
      .bus        (bus),
      .busy       (busy),
      .sweep_done (sweep_done),
      .overrun    (overrun)
   );

   int   vectors = 0;
   int   miscompares = 0;
   int   done_cnt = 0;
   bit   rdy_rand = 0;
   exp_t sb_q[$];
   int   m_cx[N_CH], m_cy[N_CH], m_r[N_CH], m_step[N_CH], m_ang[N_CH];

   initial begin
      CLK = 0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic note_fail(input string name, input string msg);
      vectors++;
      miscompares++;
      $display("FAIL %s: %s (t=%0t)", name, msg, $time);
   endtask

   function automatic int fit(input int v);
`ifdef ORBIT_CLAMP_EN
      if (v < 0) return 0;
      if (v > CMOD - 1) return CMOD - 1;
      return v;
`else
      return ((v % CMOD) + CMOD) % CMOD;
`endif
   endfunction

   // Reference: point on the circle from real-valued trig, 10-bit fixed-point factors.
   function automatic exp_t model_point(input int ch);
      exp_t e;
      real  th, s, c;
      int   sm, cm, dx, dy;
      th = 2.0 * PI * real'(m_ang[ch]) / real'(FULL);
      s  = $sin(th);
      c  = $cos(th);
      sm = $rtoi(1024.0 * ((s < 0.0) ? -s : s) + 0.5);
      cm = $rtoi(1024.0 * ((c < 0.0) ? -c : c) + 0.5);
      dx = (m_r[ch] * cm + 512) / 1024;
      dy = (m_r[ch] * sm + 512) / 1024;
      e.ch = ch;
      e.x  = fit((c < 0.0) ? m_cx[ch] - dx : m_cx[ch] + dx);
      e.y  = fit((s < 0.0) ? m_cy[ch] - dy : m_cy[ch] + dy);
      return e;
   endfunction

   task automatic model_sweep();
      for (int ch = 0; ch < N_CH; ch++) begin
         sb_q.push_back(model_point(ch));
         m_ang[ch] = (m_ang[ch] + m_step[ch]) % FULL;
      end
   endtask

   task automatic model_reset();
      for (int ch = 0; ch < N_CH; ch++) begin
         m_cx[ch] = 0; m_cy[ch] = 0; m_r[ch] = 0; m_step[ch] = 0; m_ang[ch] = 0;
      end
   endtask

   task automatic cfg_write(input int ch, input int cx, input int cy, input int r,
                            input int step, input int phase);
      @(negedge CLK);
      bus.cfg_ch       = CH_W'(ch);
      bus.cfg_cx       = COORD_W'(cx);
      bus.cfg_cy       = COORD_W'(cy);
      bus.cfg_r        = COORD_W'(r);
      bus.cfg_step     = ANGLE_W'(step);
      bus.cfg_phase    = ANGLE_W'(phase);
      bus.cfg_we       = 1'b1;
      bus.cfg_phase_we = 1'b1;
      @(negedge CLK);
      bus.cfg_we       = 1'b0;
      bus.cfg_phase_we = 1'b0;
      m_cx[ch] = cx; m_cy[ch] = cy; m_r[ch] = r; m_step[ch] = step; m_ang[ch] = phase;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n;
      n = 0;
      do begin
         @(negedge CLK); #2;
         n++;
      end while ((busy || sb_q.size() != 0) && n < budget);
      if (busy || sb_q.size() != 0)
         note_fail(tag, $sformatf("got busy=%0d with %0d outputs outstanding after %0d cycles, expected idle and drained",
                                  busy, sb_q.size(), n));
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int n;
      n = 0;
      while (!bus.out_valid && n < budget) begin
         @(negedge CLK);
         n++;
      end
      if (!bus.out_valid) note_fail(tag, $sformatf("got no out_valid within %0d cycles, expected one", budget));
   endtask

   // Tick from idle, measure LOAD-to-valid latency and check the first result.
   task automatic tick_measure(input string tag, input int ex, input int ey);
      int lat;
      @(negedge CLK);
      frame_tick = 1'b1;
      model_sweep();
      @(negedge CLK);
      frame_tick = 1'b0;
      check({tag, "_busy_in_load"}, busy, 1);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
      check({tag, "_latency"}, lat, 4);
      check({tag, "_ch"}, int'(bus.out_ch), 0);
      check({tag, "_x"}, int'(bus.out_x), ex);
      check({tag, "_y"}, int'(bus.out_y), ey);
   endtask

   // Random backpressure, changed just after each rising edge.
   initial begin
      forever begin
         @(posedge CLK); #1;
         if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: pops the scoreboard on every transfer and checks stalled data is held.
   initial begin
      bit   hold;
      exp_t h, e;
      hold = 0;
      forever begin
         @(negedge CLK); #1;
         if (!Reset_n) begin
            hold = 0;
         end else begin
            if (sweep_done) done_cnt++;
            if (hold) begin
               check("stall_valid", int'(bus.out_valid), 1);
               check("stall_ch", int'(bus.out_ch), h.ch);
               check("stall_x", int'(bus.out_x), h.x);
               check("stall_y", int'(bus.out_y), h.y);
            end
            hold = 0;
            if (bus.out_valid) begin
               if (bus.out_ready) begin
                  if (sb_q.size() == 0) begin
                     note_fail("unexpected_output", $sformatf("got ch=%0d x=%0d y=%0d, expected no output",
                                                              bus.out_ch, bus.out_x, bus.out_y));
                  end else begin
                     e = sb_q.pop_front();
                     check("out_ch", int'(bus.out_ch), e.ch);
                     check("out_x", int'(bus.out_x), e.x);
                     check("out_y", int'(bus.out_y), e.y);
                  end
               end else begin
                  hold = 1;
                  h.ch = int'(bus.out_ch);
                  h.x  = int'(bus.out_x);
                  h.y  = int'(bus.out_y);
               end
            end
         end
      end
   end

   initial begin
      int lat, d0, extra, nv;
      Reset_n          = 1'b0;
      frame_tick       = 1'b0;
      bus.cfg_we       = 1'b0;
      bus.cfg_phase_we = 1'b0;
      bus.cfg_ch       = '0;
      bus.cfg_cx       = '0;
      bus.cfg_cy       = '0;
      bus.cfg_r        = '0;
      bus.cfg_step     = '0;
      bus.cfg_phase    = '0;
      bus.out_ready    = 1'b1;
      model_reset();
      repeat (3) @(negedge CLK);
      check("rst_busy", busy, 0);
      check("rst_valid", int'(bus.out_valid), 0);
      check("rst_done", sweep_done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_ch", int'(bus.out_ch), 0);
      check("rst_x", int'(bus.out_x), 0);
      check("rst_y", int'(bus.out_y), 0);
      Reset_n = 1'b1;

      // basic orbit at the four cardinal angles; step 0 keeps the angle fixed
      cfg_write(0, 320, 240, 100, 0, 0);
      tick_measure("a0", 420, 240);
      wait_idle(200, "a0_idle");
      tick_measure("a0_again", 420, 240);
      wait_idle(200, "a0_again_idle");
      cfg_write(0, 320, 240, 100, 0, 128);
      tick_measure("a128", 320, 340);
      wait_idle(200, "a128_idle");
      cfg_write(0, 320, 240, 100, 0, 256);
      tick_measure("a256", 220, 240);
      wait_idle(200, "a256_idle");
      cfg_write(0, 320, 240, 100, 0, 384);
      tick_measure("a384", 320, 140);
      wait_idle(200, "a384_idle");

      // negative step wraps below zero; third sweep sees the 510 write-back
      cfg_write(1, 100, 100, 50, FULL - 1, 0);
      for (int s = 0; s < 3; s++) begin
         d0 = done_cnt;
         @(negedge CLK); frame_tick = 1'b1; model_sweep();
         @(negedge CLK); frame_tick = 1'b0;
         wait_idle(200, "negstep_idle");
         check("negstep_done", done_cnt - d0, 1);
      end

      // backpressure: hold ch0 for 10 cycles, then ch1 must follow 4 cycles later
      bus.out_ready = 1'b0;
      @(negedge CLK); frame_tick = 1'b1; model_sweep();
      @(negedge CLK); frame_tick = 1'b0;
      wait_valid(20, "stall_first_valid");
      repeat (10) @(negedge CLK);
      bus.out_ready = 1'b1;
      @(negedge CLK);
      bus.out_ready = 1'b0;
      check("stall_release_valid", int'(bus.out_valid), 0);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
      check("next_ch_latency", lat, 4);
      check("next_ch_id", int'(bus.out_ch), 1);
      bus.out_ready = 1'b1;
      wait_idle(200, "stall_idle");

      // randomized configs, backpressure and occasional queued second sweep
      for (int it = 0; it < 25; it++) begin
         for (int w = 0; w < int'($urandom_range(1, 3)); w++)
            cfg_write(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, CMOD - 1)),
                      int'($urandom_range(0, CMOD - 1)), int'($urandom_range(0, CMOD - 1)),
                      int'($urandom_range(0, FULL - 1)), int'($urandom_range(0, FULL - 1)));
         rdy_rand = 1'($urandom_range(0, 1));
         if (!rdy_rand) bus.out_ready = 1'b1;
         extra = ($urandom_range(0, 3) == 0) ? 1 : 0;
         d0 = done_cnt;
         @(negedge CLK); frame_tick = 1'b1; model_sweep();
         @(negedge CLK); frame_tick = 1'b0;
         if (extra != 0) begin
            repeat ($urandom_range(1, 3)) @(negedge CLK);
            frame_tick = 1'b1; model_sweep();
            @(negedge CLK); frame_tick = 1'b0;
         end
         wait_idle(2000, "rand_idle");
         check("rand_done_count", done_cnt - d0, 1 + extra);
         rdy_rand = 1'b0;
         bus.out_ready = 1'b1;
      end
      check("no_overrun_yet", overrun, 0);

      // three back-to-back ticks: one starts, one pends, one overruns
      bus.out_ready = 1'b0;
      d0 = done_cnt;
      @(negedge CLK); frame_tick = 1'b1; model_sweep();
      @(negedge CLK); model_sweep();
      @(negedge CLK);
      @(negedge CLK); frame_tick = 1'b0;
      check("overrun_set", overrun, 1);
      bus.out_ready = 1'b1;
      wait_idle(400, "overrun_idle");
      check("overrun_done_count", done_cnt - d0, 2);
      check("overrun_sticky", overrun, 1);

      // left-edge underflow: wrap or clamp
      cfg_write(0, 10, 240, 50, 0, 256);
`ifdef ORBIT_CLAMP_EN
      tick_measure("edge", 0, 240);
`else
      tick_measure("edge", 984, 240);
`endif
      wait_idle(200, "edge_idle");

      // zero radius returns the centre regardless of angle
      cfg_write(2, 700, 33, 0, 77, 300);
      for (int s = 0; s < 2; s++) begin
         @(negedge CLK); frame_tick = 1'b1; model_sweep();
         @(negedge CLK); frame_tick = 1'b0;
         wait_idle(200, "zero_r_idle");
      end

      // reset while a result is waiting in EMIT
      bus.out_ready = 1'b0;
      @(negedge CLK); frame_tick = 1'b1; model_sweep();
      @(negedge CLK); frame_tick = 1'b0;
      wait_valid(20, "rst_emit_valid");
      Reset_n = 1'b0;
      #1;
      check("rst_emit_valid_low", int'(bus.out_valid), 0);
      check("rst_emit_busy", busy, 0);
      check("rst_emit_overrun", overrun, 0);
      check("rst_emit_x", int'(bus.out_x), 0);
      sb_q.delete();
      model_reset();
      repeat (2) @(negedge CLK);
      Reset_n = 1'b1;
      bus.out_ready = 1'b1;
      nv = 0;
      repeat (20) begin
         @(negedge CLK);
         if (bus.out_valid) nv++;
      end
      check("post_reset_quiet", nv, 0);

      // recovery sweep from all-zero registers
      @(negedge CLK); frame_tick = 1'b1; model_sweep();
      @(negedge CLK); frame_tick = 1'b0;
      wait_idle(200, "recover_idle");

      repeat (3) @(negedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
